// File: rtl/i2s_tx_out.sv
// ----------------------------------------------------------------------------
// i2s_tx_out
//   Last stage of the FX chain. Captures stereo samples strobed by sample_en
//   and serialises them to an external DAC as an I2S master (BCLK, LRCLK,
//   SDATA all derived from clk). One pending-sample slot decouples the FX-chain
//   sample timing from the frame timing.
//
//   Optional feature macro: I2S_LJ_EN
//     defined   -> left-justified format (MSB coincides with LRCLK transition)
//     undefined -> standard I2S (MSB one BCLK after the LRCLK transition)
//
// Ports
//   clk        system clock
//   reset_n    synchronous, active-low reset
//   audio_in   stereo sample, [0]=left, [1]=right, two's complement
//   sample_en  1-clk strobe, audio_in valid
//   i2s_bclk   bit clock, period 2*CLK_DIV clk
//   i2s_lrclk  word select, 0=left slot, 1=right slot
//   i2s_sdata  serial data, MSB first
//   underrun   1-clk pulse: frame loaded with the repeated previous sample
//   overrun    1-clk pulse: pending sample overwritten (older one dropped)
// ----------------------------------------------------------------------------
module i2s_tx_out #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic                   sample_en,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);

  if (SLOT_W < DATA_W + 1) begin : g_slot_chk
    $error("i2s_tx_out: SLOT_W must be >= DATA_W+1");
  end
  if (CLK_DIV < 1) begin : g_div_chk
    $error("i2s_tx_out: CLK_DIV must be >= 1");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Each channel MSB-aligned in its slot, left slot transmitted first.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0][DATA_W-1:0] s);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1 -: DATA_W] = s[0];
    f[SLOT_W-1 -: DATA_W]  = s[1];
    return f;
  endfunction

  state_t                   r_state;
  logic [DIV_W-1:0]         r_div;
  logic [CNT_W-1:0]         r_bit_cnt;
  logic                     r_bclk;
  logic                     r_lrclk;
  logic                     r_sdata;
  logic                     r_underrun;
  logic                     r_overrun;
  logic [FRAME_W-1:0]       r_shift;
  logic [1:0][DATA_W-1:0]   r_pend;
  logic                     r_pend_full;
  logic [1:0][DATA_W-1:0]   r_last;
`ifndef I2S_LJ_EN
  // Holds the bit shifted out on the previous falling edge (one-BCLK delay).
  logic                     r_dly;
`endif

  logic                     w_start;
  logic                     w_fall;
  logic [CNT_W-1:0]         w_cnt_next;
  logic                     w_load;
  logic                     w_load_any;
  logic                     w_shift_evt;
  logic [1:0][DATA_W-1:0]   w_src;
  logic                     w_src_repeat;
  logic [FRAME_W-1:0]       w_frame;
  logic                     w_out_bit;
  logic [FRAME_W-1:0]       w_shift_next;

  // Falling-edge / frame-load detection and load-source selection.
  always_comb begin
    w_start      = 1'b0;
    w_fall       = 1'b0;
    w_src        = r_last;
    w_src_repeat = 1'b0;
    if (r_state == ST_IDLE) begin
      w_start = sample_en;
      w_src   = audio_in;
    end else begin
      w_fall = (r_div == DIV_MAX) && r_bclk;
      if (sample_en) begin
        w_src = audio_in;
      end else if (r_pend_full) begin
        w_src = r_pend;
      end else begin
        w_src        = r_last;
        w_src_repeat = 1'b1;
      end
    end
    w_cnt_next   = (r_bit_cnt == CNT_MAX) ? '0 : r_bit_cnt + CNT_W'(1);
    w_load       = w_fall && (w_cnt_next == '0);
    w_load_any   = w_start || w_load;
    w_shift_evt  = w_start || w_fall;
    w_frame      = build_frame(w_src);
    w_out_bit    = w_load_any ? w_frame[FRAME_W-1] : r_shift[FRAME_W-1];
    w_shift_next = w_load_any ? {w_frame[FRAME_W-2:0], 1'b0}
                              : {r_shift[FRAME_W-2:0], 1'b0};
  end

  // Controller FSM, clock divider, serialiser and pending-sample slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
      r_shift     <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_last      <= '0;
`ifndef I2S_LJ_EN
      r_dly       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_underrun <= 1'b0;
          r_overrun  <= 1'b0;
          if (w_start) begin
            // RUN entry is treated as the first falling edge, bit_cnt = 0.
            r_state   <= ST_RUN;
            r_div     <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_lrclk   <= 1'b0;
            r_last    <= audio_in;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_underrun <= w_load && w_src_repeat;
          r_overrun  <= !w_load && sample_en && r_pend_full;
          if (r_div == DIV_MAX) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
          if (w_fall) begin
            r_bit_cnt <= w_cnt_next;
            r_lrclk   <= (w_cnt_next >= SLOT_CNT);
          end else begin
            r_bit_cnt <= r_bit_cnt;
          end
          if (w_load) begin
            // Bypass or pending consumed: the slot is always empty after a load.
            r_last      <= w_src;
            r_pend_full <= 1'b0;
          end else if (sample_en) begin
            r_pend      <= audio_in;
            r_pend_full <= 1'b1;
          end else begin
            r_pend_full <= r_pend_full;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_shift_evt) begin
        r_shift <= w_shift_next;
`ifdef I2S_LJ_EN
        r_sdata <= w_out_bit;
`else
        r_sdata <= r_dly;
        r_dly   <= w_out_bit;
`endif
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;
  assign underrun  = r_underrun;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2s_tx_out.sv
// ----------------------------------------------------------------------------
// tb_i2s_tx_out
//   Directed + randomized bench for i2s_tx_out (DATA_W=16, SLOT_W=32,
//   CLK_DIV=2). A reference model derives every output from the time elapsed
//   since the first capture and the sample-selection rules; outputs are
//   compared each clk on the falling clk edge. Honors I2S_LJ_EN.
// ----------------------------------------------------------------------------
module tb_i2s_tx_out;

  localparam int DATA_W    = 16;
  localparam int SLOT_W    = 32;
  localparam int CLK_DIV   = 2;
  localparam int BCLK_CLK  = 2 * CLK_DIV;
  localparam int FRAME_CLK = 2 * SLOT_W * BCLK_CLK;

  logic                   clk;
  logic                   reset_n;
  logic [1:0][DATA_W-1:0] audio_in;
  logic                   sample_en;
  logic                   i2s_bclk;
  logic                   i2s_lrclk;
  logic                   i2s_sdata;
  logic                   underrun;
  logic                   overrun;

  i2s_tx_out #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .audio_in  (audio_in),
    .sample_en (sample_en),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic              m_running = 1'b0;
  int                m_p = 0;
  logic [DATA_W-1:0] m_cur_l = '0, m_cur_r = '0;
  logic [DATA_W-1:0] m_last_l = '0, m_last_r = '0;
  logic [DATA_W-1:0] m_pend_l = '0, m_pend_r = '0;
  logic              m_pend_full = 1'b0;
  logic              m_un = 1'b0, m_ov = 1'b0;

  // Observation helpers
  int          obs_un = 0;
  int          obs_ov = 0;
  logic        prev_bclk = 1'b0;
  logic [63:0] rx_word = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bit i of the transmitted frame (0 = first out after the frame boundary).
  function automatic logic frame_bit(input int i, input logic [DATA_W-1:0] l,
                                     input logic [DATA_W-1:0] r);
    int pos;
    pos = i % SLOT_W;
    if (pos >= DATA_W) return 1'b0;
    return (i < SLOT_W) ? l[DATA_W-1-pos] : r[DATA_W-1-pos];
  endfunction

  function automatic logic stream_bit(input int b, input logic [DATA_W-1:0] l,
                                      input logic [DATA_W-1:0] r);
`ifdef I2S_LJ_EN
    return frame_bit(b, l, r);
`else
    return (b == 0) ? 1'b0 : frame_bit(b - 1, l, r);
`endif
  endfunction

  // Whole frame as seen on the rising BCLK edges, first bit in the MSB.
  function automatic logic [63:0] exp_word(input logic [DATA_W-1:0] l,
                                           input logic [DATA_W-1:0] r);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 2 * SLOT_W; b++) w = {w[62:0], stream_bit(b, l, r)};
    return w;
  endfunction

  // Apply the sample-selection rules for one clk edge.
  task automatic model_edge();
    m_un = 1'b0;
    m_ov = 1'b0;
    if (!reset_n) begin
      m_running   = 1'b0;
      m_pend_full = 1'b0;
      m_last_l    = '0;
      m_last_r    = '0;
    end else if (!m_running) begin
      if (sample_en) begin
        m_running = 1'b1;
        m_p       = 0;
        m_cur_l   = audio_in[0];
        m_cur_r   = audio_in[1];
        m_last_l  = m_cur_l;
        m_last_r  = m_cur_r;
        rx_word   = '0;
      end
    end else begin
      m_p++;
      if (m_p % FRAME_CLK == 0) begin
        if (sample_en) begin
          m_cur_l = audio_in[0];
          m_cur_r = audio_in[1];
        end else if (m_pend_full) begin
          m_cur_l = m_pend_l;
          m_cur_r = m_pend_r;
        end else begin
          m_cur_l = m_last_l;
          m_cur_r = m_last_r;
          m_un    = 1'b1;
        end
        m_pend_full = 1'b0;
        m_last_l    = m_cur_l;
        m_last_r    = m_cur_r;
      end else if (sample_en) begin
        if (m_pend_full) m_ov = 1'b1;
        m_pend_full = 1'b1;
        m_pend_l    = audio_in[0];
        m_pend_r    = audio_in[1];
      end
    end
  endtask

  task automatic check_outputs();
    logic e_bclk, e_lr, e_sd;
    int b;
    if (m_running) begin
      b      = (m_p / BCLK_CLK) % (2 * SLOT_W);
      e_bclk = ((m_p / CLK_DIV) % 2) == 1;
      e_lr   = (b >= SLOT_W);
      e_sd   = stream_bit(b, m_cur_l, m_cur_r);
    end else begin
      e_bclk = 1'b0;
      e_lr   = 1'b0;
      e_sd   = 1'b0;
    end
    chk("bclk", 64'(i2s_bclk), 64'(e_bclk));
    chk("lrclk", 64'(i2s_lrclk), 64'(e_lr));
    chk("sdata", 64'(i2s_sdata), 64'(e_sd));
    chk("underrun", 64'(underrun), 64'(m_un));
    chk("overrun", 64'(overrun), 64'(m_ov));
    if (underrun === 1'b1) obs_un++;
    if (overrun === 1'b1) obs_ov++;
    if (i2s_bclk === 1'b1 && prev_bclk === 1'b0) rx_word = {rx_word[62:0], i2s_sdata};
    prev_bclk = i2s_bclk;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_running && m_p < target && guard < 20000) begin
      tick();
      guard++;
    end
    chk("run_to_reached", 64'(m_p >= target), 64'(1));
  endtask

  task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    sample_en   = 1'b1;
    audio_in[0] = l;
    audio_in[1] = r;
    tick();
    sample_en   = 1'b0;
  endtask

  initial begin
    int guard;
    logic [DATA_W-1:0] rl, rr;
    reset_n   = 1'b0;
    sample_en = 1'b0;
    audio_in  = '0;

    // Reset: all outputs low.
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();

    // Test 1: first capture, one full frame of A5C3/0F01.
    send(16'hA5C3, 16'h0F01);
    run_to(FRAME_CLK - 1);
    chk("frame0_word", rx_word, exp_word(16'hA5C3, 16'h0F01));

    // Test 2 + 3: frame 1 repeats with underrun; two samples mid-frame overrun.
    run_to(FRAME_CLK + 40);
    send(16'h1111, 16'h2222);
    repeat (30) tick();
    send(16'h3333, 16'h4444);
    run_to(2 * FRAME_CLK - 1);
    chk("frame1_word", rx_word, exp_word(16'hA5C3, 16'h0F01));
    chk("underrun_cnt_t2", 64'(obs_un), 64'(1));
    chk("overrun_cnt_t3", 64'(obs_ov), 64'(1));

    // Frame 2 carries the surviving pending sample.
    run_to(3 * FRAME_CLK - 1);
    chk("frame2_word", rx_word, exp_word(16'h3333, 16'h4444));

    // Test 4: sample_en exactly on the frame-load clk.
    send(16'h7FFF, 16'h8000);
    run_to(4 * FRAME_CLK - 1);
    chk("frame3_word", rx_word, exp_word(16'h7FFF, 16'h8000));
    chk("underrun_cnt_t4", 64'(obs_un), 64'(1));
    chk("overrun_cnt_t4", 64'(obs_ov), 64'(1));

    // Random traffic across several frames.
    for (int i = 0; i < 900; i++) begin
      sample_en   = ($urandom_range(0, 99) < 2);
      audio_in[0] = DATA_W'($urandom);
      audio_in[1] = DATA_W'($urandom);
      tick();
    end
    sample_en = 1'b0;

    // Test 5: reset pulse at bit_cnt = 40, then stay idle.
    guard = 0;
    while (((m_p / BCLK_CLK) % (2 * SLOT_W)) != 40 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("reach_bitcnt40", 64'(guard < 2000), 64'(1));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (30) tick();

    // Restart with a random sample and check a whole frame.
    rl = DATA_W'($urandom);
    rr = DATA_W'($urandom);
    send(rl, rr);
    run_to(FRAME_CLK - 1);
    chk("restart_word", rx_word, exp_word(rl, rr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
